// File: rtl/pipe_buf_stage_pkg.sv
// Shared types for the elastic pipeline buffer stage: FSM encoding, the
// bubble reference instruction and the stage payload structs.
package Pipe_Buf_Reg_PKG;

  typedef enum logic [1:0] {PB_EMPTY, PB_ONE, PB_FULL} pipe_buf_state_e;

  // addi x0, x0, 0 -- what a flushed slot decodes as downstream
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_s;

endpackage

// File: rtl/pipe_buf_stage.sv
// Elastic valid/ready pipeline buffer between two RV32I stages, with optional
// skid entry, synchronous flush and a saturating backpressure counter.
module pipe_buf_stage
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_buf_state_e   state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_fire;

  assign in_fire = in_valid & in_ready;

  // NOTE: sequential blocks use only non-blocking assignments so every flop
  // samples the pre-edge value of the others, regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PB_EMPTY;
      main_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;

    // NOTE: every variable gets a default at the top of the comb block, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = PB_EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end else begin
        unique case (state_q)
          PB_EMPTY: if (in_fire) begin
            main_d  = in_data;
            state_d = PB_ONE;
          end
          PB_ONE: begin
            if (in_fire && out_ready) begin
              main_d = in_data;
            end else if (in_fire) begin
              skid_d  = in_data;
              state_d = PB_FULL;
            end else if (out_ready) begin
              state_d = PB_EMPTY;
            end
          end
          PB_FULL: if (out_ready) begin
            main_d  = skid_q;
            state_d = PB_ONE;
          end
          default: state_d = PB_EMPTY;
        endcase
      end
    end

    // in_ready is a flop so out_ready never reaches it combinationally
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        skid_q     <= '0;
        in_ready_q <= 1'b1;
      end else begin
        skid_q     <= skid_d;
        in_ready_q <= (state_d != PB_FULL);
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_single
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (flush) begin
        state_d = PB_EMPTY;
        main_d  = '0;
      end else if (in_fire) begin
        main_d  = in_data;
        state_d = PB_ONE;
      end else if (out_valid && out_ready) begin
        state_d = PB_EMPTY;
      end
    end

    assign in_ready = !out_valid || out_ready;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    out_valid = (state_q != PB_EMPTY);
    out_data  = main_q;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Bench for pipe_buf_stage: three instances (skid, single entry, 4-bit counter)
// checked every cycle against a queue-occupancy reference model.
module tb_pipe_buf_stage;
  import Pipe_Buf_Reg_PKG::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  iv, rdy, fl;
  logic [2:0]  ir, ov;
  logic [31:0] din [3];
  logic [31:0] od  [3];
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: ordered slots, occupancy, stall count, cleared flag
  int          m_n   [3];
  logic [31:0] m_s0  [3];
  logic [31:0] m_s1  [3];
  int          m_cnt [3];
  bit          m_clr [3];
  int          m_cap [3] = '{2, 1, 2};
  int          m_max [3] = '{65535, 65535, 15};

  always #5 clk = ~clk;

  pipe_buf_stage #(.DATA_W(32), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(din[0]), .out_valid(ov[0]), .out_ready(rdy[0]), .out_data(od[0]),
    .stall_cnt(sc0));

  pipe_buf_stage #(.DATA_W(32), .SKID(0), .CNT_W(16)) u_single (
    .clk(clk), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(din[1]), .out_valid(ov[1]), .out_ready(rdy[1]), .out_data(od[1]),
    .stall_cnt(sc1));

  pipe_buf_stage #(.DATA_W(32), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(din[2]), .out_valid(ov[2]), .out_ready(rdy[2]), .out_data(od[2]),
    .stall_cnt(sc2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sc_of(input int k);
    case (k)
      0:       return 32'(sc0);
      1:       return 32'(sc1);
      default: return 32'(sc2);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_n[k] = 0; m_s0[k] = '0; m_s1[k] = '0; m_cnt[k] = 0; m_clr[k] = 1'b1;
    end
  endtask

  task automatic idle_all();
    iv = '0; rdy = '1; fl = '0;
    for (int k = 0; k < 3; k++) din[k] = '0;
  endtask

  // called at posedge+1 with inputs already driven; returns at next posedge+1
  task automatic step(input string tag);
    bit inf [3];
    bit outf [3];
    bit exp_rdy;
    #2;
    for (int k = 0; k < 3; k++) begin
      exp_rdy = (m_cap[k] == 2) ? (m_n[k] < 2) : (m_n[k] == 0 || rdy[k]);
      check($sformatf("%s d%0d in_ready", tag, k), 32'(ir[k]), 32'(exp_rdy));
      check($sformatf("%s d%0d out_valid", tag, k), 32'(ov[k]), 32'(m_n[k] > 0));
      if (m_n[k] > 0)
        check($sformatf("%s d%0d out_data", tag, k), od[k], m_s0[k]);
      else if (m_clr[k])
        check($sformatf("%s d%0d out_data_zero", tag, k), od[k], 32'h0);
      check($sformatf("%s d%0d stall_cnt", tag, k), sc_of(k), 32'(m_cnt[k]));
      inf[k]  = iv[k] && exp_rdy;
      outf[k] = (m_n[k] > 0) && rdy[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (m_n[k] > 0 && !rdy[k] && m_cnt[k] < m_max[k]) m_cnt[k]++;
      if (fl[k]) begin
        m_n[k] = 0; m_s0[k] = '0; m_s1[k] = '0; m_clr[k] = 1'b1;
      end else begin
        if (outf[k]) begin
          m_s0[k] = m_s1[k];
          m_n[k]--;
        end
        if (inf[k]) begin
          if (m_n[k] == 0) m_s0[k] = din[k];
          else             m_s1[k] = din[k];
          m_n[k]++;
          m_clr[k] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stream [4];
    stream = '{32'h11, 32'h22, 32'h33, NOP_INSTR};

    idle_all();
    reset = 1'b1;
    model_reset();
    #3;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("por d%0d in_ready", k), 32'(ir[k]), 32'h1);
      check($sformatf("por d%0d out_valid", k), 32'(ov[k]), 32'h0);
      check($sformatf("por d%0d out_data", k), od[k], 32'h0);
      check($sformatf("por d%0d stall_cnt", k), sc_of(k), 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // back-to-back stream through the skid instance
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; din[0] = stream[i];
      step("stream");
    end
    iv[0] = 1'b0;
    repeat (2) step("stream_drain");

    // two beats under backpressure, then release
    rdy[0] = 1'b0;
    iv[0] = 1'b1; din[0] = 32'hA; step("bp_a");
    din[0] = 32'hB;               step("bp_b");
    iv[0] = 1'b1; din[0] = 32'hE; step("bp_full");
    iv[0] = 1'b0;
    repeat (2) step("bp_hold");
    rdy[0] = 1'b1;
    repeat (3) step("bp_release");

    // flush while full with a beat offered
    rdy[0] = 1'b0;
    iv[0] = 1'b1; din[0] = 32'hA1; step("fl_a");
    din[0] = 32'hB1;               step("fl_b");
    fl[0] = 1'b1; din[0] = 32'hC;  step("fl_kill");
    fl[0] = 1'b0; iv[0] = 1'b0; rdy[0] = 1'b1;
    repeat (3) step("fl_after");

    // single-entry instance: combinational in_ready and same-cycle replacement
    rdy[1] = 1'b0;
    iv[1] = 1'b1; din[1] = 32'h55; step("se_load");
    iv[1] = 1'b0;                  step("se_hold");
    iv[1] = 1'b1; din[1] = 32'h66; step("se_blocked");
    rdy[1] = 1'b1; din[1] = 32'h77; step("se_replace");
    iv[1] = 1'b0;
    repeat (2) step("se_drain");

    // saturation of the 4-bit counter
    rdy[2] = 1'b0;
    iv[2] = 1'b1; din[2] = 32'h9; step("sat_load");
    iv[2] = 1'b0;
    repeat (20) step("sat_hold");
    check("sat_final stall_cnt", 32'(sc2), 32'd15);
    rdy[2] = 1'b1;
    repeat (2) step("sat_drain");

    // asynchronous reset while the skid instance is full
    rdy[0] = 1'b0;
    iv[0] = 1'b1; din[0] = 32'hD1; step("ar_a");
    din[0] = 32'hD2;               step("ar_b");
    iv[0] = 1'b0;                  step("ar_full");
    #2;
    reset = 1'b1;
    #1;
    check("ar in_ready", 32'(ir[0]), 32'h1);
    check("ar out_valid", 32'(ov[0]), 32'h0);
    check("ar out_data", od[0], 32'h0);
    check("ar stall_cnt", 32'(sc0), 32'h0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    idle_all();

    // randomized traffic on all three instances
    repeat (600) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]  = 1'($urandom_range(0, 1));
        rdy[k] = ($urandom_range(0, 9) < 6);
        fl[k]  = ($urandom_range(0, 19) == 0);
        din[k] = ($urandom_range(0, 15) == 0) ? NOP_INSTR : $urandom;
      end
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
